// File: rtl/mem_arbiter2.sv
// rtl/mem_arbiter2.sv - two-requester arbiter for one single-port synchronous memory
// Same-cycle grant, round-robin or starvation-bounded fixed priority, read response steering.
module mem_arbiter2 #(
  parameter int POLICY       = 1,
  parameter int STARVE_LIMIT = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        p0_valid,
  input  logic        p0_write,
  input  logic [3:0]  p0_wmask,
  input  logic [31:0] p0_wdata,
  input  logic [31:0] p0_addr,
  output logic        p0_ready,
  output logic        p0_rvalid,
  output logic [31:0] p0_rdata,
  input  logic        p1_valid,
  input  logic        p1_write,
  input  logic [3:0]  p1_wmask,
  input  logic [31:0] p1_wdata,
  input  logic [31:0] p1_addr,
  output logic        p1_ready,
  output logic        p1_rvalid,
  output logic [31:0] p1_rdata,
  output logic        mem_valid,
  output logic        mem_write,
  output logic [3:0]  mem_wmask,
  output logic [31:0] mem_wdata,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic       last_grant_q, last_grant_d;
  logic [7:0] starve_cnt_q, starve_cnt_d;
  logic       rsp_pend_q, rsp_pend_d;
  logic       rsp_port_q, rsp_port_d;
  logic       gnt1;

  always_comb begin
    gnt1 = 1'b0;
    if (p1_valid && !p0_valid) begin
      gnt1 = 1'b1;
    end else if (p1_valid && p0_valid) begin
      if (POLICY == 1) begin
        gnt1 = ~last_grant_q;
      end else begin
        gnt1 = (starve_cnt_q == LIMIT);
      end
    end
  end

  assign p0_ready  = p0_valid & ~gnt1;
  assign p1_ready  = p1_valid & gnt1;

  // With no grant the port 0 fields still drive addr/wdata, but write strobes stay low.
  assign mem_valid = p0_valid | p1_valid;
  assign mem_write = gnt1 ? p1_write : (p0_valid & p0_write);
  assign mem_wmask = gnt1 ? p1_wmask : (p0_valid ? p0_wmask : 4'b0000);
  assign mem_wdata = gnt1 ? p1_wdata : p0_wdata;
  assign mem_addr  = gnt1 ? p1_addr  : p0_addr;

  assign p0_rdata  = mem_rdata;
  assign p1_rdata  = mem_rdata;
  assign p0_rvalid = rsp_pend_q & ~rsp_port_q;
  assign p1_rvalid = rsp_pend_q & rsp_port_q;

  always_comb begin
    last_grant_d = mem_valid ? gnt1 : last_grant_q;
    starve_cnt_d = 8'd0;
    if (p1_valid && !gnt1) begin
      starve_cnt_d = (starve_cnt_q == LIMIT) ? starve_cnt_q : starve_cnt_q + 8'd1;
    end
    rsp_pend_d = mem_valid & ~mem_write;
    rsp_port_d = gnt1;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      last_grant_q <= 1'b1;
      starve_cnt_q <= 8'd0;
      rsp_pend_q   <= 1'b0;
      rsp_port_q   <= 1'b0;
    end else begin
      last_grant_q <= last_grant_d;
      starve_cnt_q <= starve_cnt_d;
      rsp_pend_q   <= rsp_pend_d;
      rsp_port_q   <= rsp_port_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter2.sv
// tb/tb_mem_arbiter2.sv - directed bench for mem_arbiter2 (round-robin and fixed-priority instances)
module tb_mem_arbiter2;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        mem_load = 1'b0;
  logic        p0_valid = 0, p0_write = 0, p1_valid = 0, p1_write = 0;
  logic [3:0]  p0_wmask = 4'b0010, p1_wmask = 4'b0010;
  logic [31:0] p0_wdata = 32'hAABBCCDD, p1_wdata = 32'hAABBCCDD;
  logic [31:0] p0_addr = 0, p1_addr = 0;

  logic        rr_p0_ready, rr_p0_rvalid, rr_p1_ready, rr_p1_rvalid;
  logic [31:0] rr_p0_rdata, rr_p1_rdata;
  logic        rr_mem_valid, rr_mem_write;
  logic [3:0]  rr_mem_wmask;
  logic [31:0] rr_mem_wdata, rr_mem_addr, rr_mem_rdata;
  logic        fp_p0_ready, fp_p0_rvalid, fp_p1_ready, fp_p1_rvalid;
  logic [31:0] fp_p0_rdata, fp_p1_rdata;
  logic        fp_mem_valid, fp_mem_write;
  logic [3:0]  fp_mem_wmask;
  logic [31:0] fp_mem_wdata, fp_mem_addr, fp_mem_rdata;

  always #5 clk = ~clk;

  mem_arbiter2 #(.POLICY(1), .STARVE_LIMIT(8)) u_rr (
    .clk(clk), .rstn(rstn),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata),
    .p0_addr(p0_addr), .p0_ready(rr_p0_ready), .p0_rvalid(rr_p0_rvalid), .p0_rdata(rr_p0_rdata),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_addr(p1_addr), .p1_ready(rr_p1_ready), .p1_rvalid(rr_p1_rvalid), .p1_rdata(rr_p1_rdata),
    .mem_valid(rr_mem_valid), .mem_write(rr_mem_write), .mem_wmask(rr_mem_wmask),
    .mem_wdata(rr_mem_wdata), .mem_addr(rr_mem_addr), .mem_rdata(rr_mem_rdata)
  );

  mem_arbiter2 #(.POLICY(0), .STARVE_LIMIT(3)) u_fp (
    .clk(clk), .rstn(rstn),
    .p0_valid(p0_valid), .p0_write(p0_write), .p0_wmask(p0_wmask), .p0_wdata(p0_wdata),
    .p0_addr(p0_addr), .p0_ready(fp_p0_ready), .p0_rvalid(fp_p0_rvalid), .p0_rdata(fp_p0_rdata),
    .p1_valid(p1_valid), .p1_write(p1_write), .p1_wmask(p1_wmask), .p1_wdata(p1_wdata),
    .p1_addr(p1_addr), .p1_ready(fp_p1_ready), .p1_rvalid(fp_p1_rvalid), .p1_rdata(fp_p1_rdata),
    .mem_valid(fp_mem_valid), .mem_write(fp_mem_write), .mem_wmask(fp_mem_wmask),
    .mem_wdata(fp_mem_wdata), .mem_addr(fp_mem_addr), .mem_rdata(fp_mem_rdata)
  );

  // One memory model per instance; word at byte address A initialises to 0xD0000000 + A.
  logic [31:0] mem_rr [256];
  logic [31:0] mem_fp [256];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem_rr[k] <= 32'hD000_0000 + 32'(k * 4);
    end else if (rr_mem_valid && rr_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (rr_mem_wmask[b]) mem_rr[rr_mem_addr[9:2]][8*b +: 8] <= rr_mem_wdata[8*b +: 8];
    end else if (rr_mem_valid) begin
      rr_mem_rdata <= mem_rr[rr_mem_addr[9:2]];
    end
  end

  always @(posedge clk) begin
    if (mem_load) begin
      for (int k = 0; k < 256; k++) mem_fp[k] <= 32'hD000_0000 + 32'(k * 4);
    end else if (fp_mem_valid && fp_mem_write) begin
      for (int b = 0; b < 4; b++)
        if (fp_mem_wmask[b]) mem_fp[fp_mem_addr[9:2]][8*b +: 8] <= fp_mem_wdata[8*b +: 8];
    end else if (fp_mem_valid) begin
      fp_mem_rdata <= mem_fp[fp_mem_addr[9:2]];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s [%0d]: got %h want %h", name, idx, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    p0_valid = 0; p1_valid = 0; p0_write = 0; p1_write = 0;
    repeat (2) @(negedge clk);
    rstn = 1'b1;
  endtask

  typedef struct {
    logic        v0, w0;
    logic [31:0] a0;
    logic        v1, w1;
    logic [31:0] a1;
    logic [1:0]  rr_rdy, fp_rdy, rr_rv, fp_rv; // bit0 = port 0, bit1 = port 1
    logic [31:0] rr_d, fp_d;
  } vec_t;

  localparam logic [31:0] R0 = 32'hD000_0000;
  localparam logic [31:0] R4 = 32'hD000_0004;
  localparam logic [31:0] IA = 32'h0000_0044;

  vec_t vec [30];

  initial begin
    vec[0]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0};
    vec[1]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b01,2'b01,R0,R0};
    vec[2]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b01,R4,R0};
    vec[3]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b10,2'b01,2'b01,R0,R0};
    vec[4]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b10,R4,R4};
    vec[5]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b01,2'b01,R0,R0};
    vec[6]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b01,R4,R0};
    vec[7]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b10,2'b01,2'b01,R0,R0};
    vec[8]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b10,R4,R4};
    vec[9]  = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b01,2'b01,R0,R0};
    vec[10] = '{1'b0,1'b0,IA,    1'b0,1'b0,32'h0, 2'b00,2'b00,2'b10,2'b01,R4,R0};
    vec[11] = '{1'b1,1'b0,32'h100,1'b0,1'b0,32'h0,2'b01,2'b01,2'b00,2'b00,32'h0,32'h0};
    vec[12] = '{1'b0,1'b0,32'h0, 1'b1,1'b0,32'h104,2'b10,2'b10,2'b01,2'b01,32'hD000_0100,32'hD000_0100};
    vec[13] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h10, 2'b10,2'b10,2'b10,2'b10,32'hD000_0104,32'hD000_0104};
    vec[14] = '{1'b1,1'b0,32'h10,1'b0,1'b0,32'h0, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0};
    vec[15] = '{1'b0,1'b0,IA,    1'b0,1'b0,32'h0, 2'b00,2'b00,2'b01,2'b01,32'hD000_CC10,32'hD000_CC10};
    vec[16] = '{1'b1,1'b0,32'h20,1'b0,1'b0,32'h0, 2'b01,2'b01,2'b00,2'b00,32'h0,32'h0};
    vec[17] = '{1'b0,1'b0,32'h0, 1'b1,1'b1,32'h30, 2'b10,2'b10,2'b01,2'b01,32'hD000_0020,32'hD000_0020};
    vec[18] = '{1'b0,1'b0,IA,    1'b0,1'b0,32'h0, 2'b00,2'b00,2'b00,2'b00,32'h0,32'h0};
    vec[19] = '{1'b0,1'b0,32'h0, 1'b1,1'b0,32'h8,  2'b10,2'b10,2'b00,2'b00,32'h0,32'h0};
    vec[20] = '{1'b1,1'b0,32'hC, 1'b0,1'b0,32'h0,  2'b01,2'b01,2'b10,2'b10,32'hD000_0008,32'hD000_0008};
    vec[21] = '{1'b0,1'b0,IA,    1'b0,1'b0,32'h0,  2'b00,2'b00,2'b01,2'b01,32'hD000_000C,32'hD000_000C};
    vec[22] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b00,2'b00,32'h0,32'h0};
    vec[23] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b01,R4,R0};
    vec[24] = '{1'b1,1'b0,32'h0, 1'b0,1'b0,32'h4, 2'b01,2'b01,2'b01,2'b01,R0,R0};
    vec[25] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b01,2'b01,R0,R0};
    vec[26] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b01,2'b10,2'b01,R4,R0};
    vec[27] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b10,2'b01,2'b01,2'b01,R0,R0};
    vec[28] = '{1'b1,1'b0,32'h0, 1'b1,1'b0,32'h4, 2'b01,2'b10,2'b10,2'b01,R4,R0};
    vec[29] = '{1'b0,1'b0,IA,    1'b0,1'b0,32'h0, 2'b00,2'b00,2'b01,2'b10,R0,R4};

    // Reset state, with the memory models loaded during reset.
    mem_load = 1'b1;
    repeat (2) @(negedge clk);
    mem_load = 1'b0;
    #1;
    check("reset_rr_rvalid", 0, 32'({rr_p1_rvalid, rr_p0_rvalid}), 32'h0);
    check("reset_fp_rvalid", 0, 32'({fp_p1_rvalid, fp_p0_rvalid}), 32'h0);
    check("reset_mem_valid", 0, 32'({rr_mem_valid, fp_mem_valid}), 32'h0);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      p0_valid = vec[i].v0; p0_write = vec[i].w0; p0_addr = vec[i].a0;
      p1_valid = vec[i].v1; p1_write = vec[i].w1; p1_addr = vec[i].a1;
      #1;
      check("rr_ready",  i, 32'({rr_p1_ready, rr_p0_ready}),   32'(vec[i].rr_rdy));
      check("fp_ready",  i, 32'({fp_p1_ready, fp_p0_ready}),   32'(vec[i].fp_rdy));
      check("rr_rvalid", i, 32'({rr_p1_rvalid, rr_p0_rvalid}), 32'(vec[i].rr_rv));
      check("fp_rvalid", i, 32'({fp_p1_rvalid, fp_p0_rvalid}), 32'(vec[i].fp_rv));
      if (vec[i].rr_rv != 2'b00)
        check("rr_rdata", i, vec[i].rr_rv[0] ? rr_p0_rdata : rr_p1_rdata, vec[i].rr_d);
      if (vec[i].fp_rv != 2'b00)
        check("fp_rdata", i, vec[i].fp_rv[0] ? fp_p0_rdata : fp_p1_rdata, vec[i].fp_d);
      if (!vec[i].v0 && !vec[i].v1) begin
        check("idle_wr_mask", i, 32'({rr_mem_write, rr_mem_wmask, fp_mem_write, fp_mem_wmask}), 32'h0);
        check("idle_addr", i, rr_mem_addr, vec[i].a0);
      end
    end

    // Reset between an accepted read and its response drops the response.
    do_reset();
    @(negedge clk);
    p0_valid = 1; p0_write = 0; p0_addr = 32'h100;
    #1;
    check("rst_mid_ready", 0, 32'(rr_p0_ready), 32'h1);
    @(posedge clk);
    #2;
    rstn = 1'b0;
    #1;
    check("rst_mid_rvalid", 0, 32'({rr_p0_rvalid, fp_p0_rvalid}), 32'h0);
    @(negedge clk);
    p0_valid = 0;
    rstn = 1'b1;
    #1;
    check("rst_rel_rvalid", 0, 32'({rr_p0_rvalid, fp_p0_rvalid}), 32'h0);
    @(negedge clk);
    p0_valid = 1; p0_addr = 32'h0; p1_valid = 1; p1_write = 0; p1_addr = 32'h4;
    #1;
    check("rst_rel_rvalid", 1, 32'({rr_p0_rvalid, fp_p0_rvalid}), 32'h0);
    check("rst_first_conflict_rr", 0, 32'({rr_p1_ready, rr_p0_ready}), 32'h1);
    check("rst_first_conflict_fp", 0, 32'({fp_p1_ready, fp_p0_ready}), 32'h1);
    @(negedge clk);
    p0_valid = 0; p1_valid = 0;
    #1;
    check("post_rst_rsp", 0, 32'({rr_p1_rvalid, rr_p0_rvalid}), 32'h1);
    check("post_rst_rdata", 0, rr_p0_rdata, R0);

    // Port 1 write held off by port 0 in the fixed-priority instance until the starve limit.
    do_reset();
    begin
      logic        waiting;
      logic [68:0] held;
      waiting = 1'b0;
      held    = '0;
      for (int c = 0; c < 5; c++) begin
        @(negedge clk);
        if (waiting)
          check("p1_hold_stable", c, 32'(held != {p1_write, p1_wmask, p1_wdata, p1_addr}), 32'h0);
        if (c < 4) begin
          p0_valid = 1; p0_write = 0; p0_addr = 32'h40;
          p1_valid = 1; p1_write = 1; p1_wmask = 4'hF; p1_wdata = 32'h1122_3344; p1_addr = 32'h80;
        end else begin
          p0_valid = 0; p1_valid = 0;
        end
        #1;
        if (c < 3) begin
          check("starve_p1_ready", c, 32'(fp_p1_ready), 32'h0);
          check("starve_mem_addr", c, fp_mem_addr, 32'h40);
          check("starve_mem_write", c, 32'(fp_mem_write), 32'h0);
        end else if (c == 3) begin
          check("starve_p1_ready", c, 32'(fp_p1_ready), 32'h1);
          check("starve_mem", c, 32'({fp_mem_write, fp_mem_wmask}), 32'h1F);
          check("starve_mem_addr", c, fp_mem_addr, 32'h80);
          check("starve_mem_wdata", c, fp_mem_wdata, 32'h1122_3344);
        end else begin
          check("idle_valid", c, 32'(fp_mem_valid), 32'h0);
          check("idle_wr_mask", c, 32'({fp_mem_write, fp_mem_wmask}), 32'h0);
        end
        waiting = p1_valid & ~fp_p1_ready;
        held    = {p1_write, p1_wmask, p1_wdata, p1_addr};
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
